// File: rtl/obstacle_scroller_if.sv
// Obstacle scroller signal bundle: game-side controls and generator
// patterns in, playfield frame and game status out.
interface obstacle_scroller_if;
    logic        start;
    logic        tick;
    logic        mode;
    logic [7:0]  col_a;
    logic [7:0]  col_b;
    logic [2:0]  bird_row;
    logic        gen_req;
    logic [63:0] frame;
    logic [7:0]  score;
    logic        collision;
    logic        playing;

    // Driver side: game control, timer, bird position and column generator
    modport master (
        output start, tick, mode, col_a, col_b, bird_row,
        input  gen_req, frame, score, collision, playing
    );

    // Scroller side
    modport slave (
        input  start, tick, mode, col_a, col_b, bird_row,
        output gen_req, frame, score, collision, playing
    );
endinterface

// File: rtl/obstacle_scroller.sv
// Obstacle scroller: shifts generator column patterns right-to-left across
// an 8x8 playfield, requests new patterns, detects bird/wall collision and
// keeps the score.
// Optional build macro SCORE_BCD_EN: score becomes two packed BCD digits
// saturating at 8'h99; otherwise score is binary saturating at 255.
module obstacle_scroller #(
    parameter int GAP      = 3,
    parameter int BIRD_COL = 1
) (
    input logic             clk,
    input logic             reset_n,
    obstacle_scroller_if.slave sc
);

    typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

    localparam logic [2:0] SLOT_LAST = 3'(GAP + 1);

    state_t      state_q;
    logic [63:0] frame_q, frame_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  tag_q, tag_d;
    logic [2:0]  slot_q, slot_d;
    logic [7:0]  lat_b_q;
    logic        lat_mode_q;
    logic        gen_req_q;
    logic        collision_q;
    logic        playing_q;
    logic [7:0]  new_col;
    logic [5:0]  bird_idx;
    logic        hit;

    // Next-column selection, shift values, collision probe and saturated score
    always_comb begin
        bird_idx = 6'(8 * BIRD_COL) + {3'b000, sc.bird_row};
        hit      = frame_q[bird_idx];

        new_col = '0;
        if (slot_q == 3'd0)
            new_col = sc.col_a;
        else if (slot_q == 3'd1 && lat_mode_q)
            new_col = lat_b_q;

        frame_d = {new_col, frame_q[63:8]};
        tag_d   = {(slot_q == 3'd0), tag_q[7:1]};
        slot_d  = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;

`ifdef SCORE_BCD_EN
        if (score_q == 8'h99)
            score_d = score_q;
        else if (score_q[3:0] == 4'd9)
            score_d = {score_q[7:4] + 4'd1, 4'd0};
        else
            score_d = {score_q[7:4], score_q[3:0] + 4'd1};
`else
        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
`endif
    end

    // Game FSM with registered frame, score and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            score_q     <= '0;
            tag_q       <= '0;
            slot_q      <= '0;
            lat_b_q     <= '0;
            lat_mode_q  <= 1'b0;
            gen_req_q   <= 1'b0;
            collision_q <= 1'b0;
            playing_q   <= 1'b0;
        end else begin
            gen_req_q <= 1'b0;
            case (state_q)
                IDLE, HIT: begin
                    if (sc.start) begin
                        state_q     <= RUN;
                        frame_q     <= '0;
                        score_q     <= '0;
                        tag_q       <= '0;
                        slot_q      <= '0;
                        collision_q <= 1'b0;
                        playing_q   <= 1'b1;
                    end
                end
                RUN: begin
                    // A collision in the same cycle as a tick freezes the playfield
                    if (hit) begin
                        state_q     <= HIT;
                        collision_q <= 1'b1;
                        playing_q   <= 1'b0;
                    end else if (sc.tick) begin
                        frame_q <= frame_d;
                        tag_q   <= tag_d;
                        slot_q  <= slot_d;
                        if (slot_q == 3'd0) begin
                            lat_b_q    <= sc.col_b;
                            lat_mode_q <= sc.mode;
                            gen_req_q  <= 1'b1;
                        end
                        if (tag_q[BIRD_COL])
                            score_q <= score_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sc.gen_req   = gen_req_q;
    assign sc.frame     = frame_q;
    assign sc.score     = score_q;
    assign sc.collision = collision_q;
    assign sc.playing   = playing_q;

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed self-checking bench for obstacle_scroller (GAP=3, BIRD_COL=1).
module tb_obstacle_scroller;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    obstacle_scroller_if sc_if ();

    obstacle_scroller #(.GAP(3), .BIRD_COL(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sc      (sc_if)
    );

    task automatic pulse_start;
        @(negedge clk) sc_if.start = 1'b1;
        @(negedge clk) sc_if.start = 1'b0;
    endtask

    task automatic tick_once;
        @(negedge clk) sc_if.tick = 1'b1;
        @(negedge clk) sc_if.tick = 1'b0;
    endtask

    task automatic test_reset;
        sc_if.start = 0; sc_if.tick = 0; sc_if.mode = 0;
        sc_if.col_a = '0; sc_if.col_b = '0; sc_if.bird_row = 3'd4;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (sc_if.frame !== 64'h0) begin miscompares++; $display("FAIL rst_frame: got %h expected %h", sc_if.frame, 64'h0); end
        vectors++; if (sc_if.score !== 8'h00) begin miscompares++; $display("FAIL rst_score: got %h expected 00", sc_if.score); end
        vectors++; if (sc_if.playing !== 1'b0) begin miscompares++; $display("FAIL rst_playing: got %b expected 0", sc_if.playing); end
        vectors++; if (sc_if.collision !== 1'b0) begin miscompares++; $display("FAIL rst_collision: got %b expected 0", sc_if.collision); end
        vectors++; if (sc_if.gen_req !== 1'b0) begin miscompares++; $display("FAIL rst_gen_req: got %b expected 0", sc_if.gen_req); end
        reset_n = 1'b1;
        sc_if.col_a = 8'hFF;
        tick_once();
        vectors++; if (sc_if.frame !== 64'h0) begin miscompares++; $display("FAIL idle_tick_frame: got %h expected %h", sc_if.frame, 64'h0); end
        vectors++; if (sc_if.gen_req !== 1'b0) begin miscompares++; $display("FAIL idle_tick_gen_req: got %b expected 0", sc_if.gen_req); end
    endtask

    task automatic test_single_wall;
        sc_if.mode = 0; sc_if.col_a = 8'hE7; sc_if.bird_row = 3'd4;
        pulse_start();
        vectors++; if (sc_if.playing !== 1'b1) begin miscompares++; $display("FAIL start_playing: got %b expected 1", sc_if.playing); end
        @(negedge clk) sc_if.tick = 1'b1;
        vectors++; if (sc_if.gen_req !== 1'b0) begin miscompares++; $display("FAIL gen_req_early: got %b expected 0", sc_if.gen_req); end
        @(negedge clk) sc_if.tick = 1'b0;
        sc_if.col_a = 8'hC3;
        vectors++; if (sc_if.frame[63:56] !== 8'hE7) begin miscompares++; $display("FAIL col7_first: got %h expected e7", sc_if.frame[63:56]); end
        vectors++; if (sc_if.frame[55:0] !== 56'h0) begin miscompares++; $display("FAIL cols_rest_first: got %h expected 0", sc_if.frame[55:0]); end
        vectors++; if (sc_if.gen_req !== 1'b1) begin miscompares++; $display("FAIL gen_req_pulse: got %b expected 1", sc_if.gen_req); end
        @(negedge clk);
        vectors++; if (sc_if.gen_req !== 1'b0) begin miscompares++; $display("FAIL gen_req_width: got %b expected 0", sc_if.gen_req); end
        repeat (4) tick_once();
        vectors++; if (sc_if.frame !== 64'h00000000_E7000000) begin miscompares++; $display("FAIL frame_tick5: got %h expected %h", sc_if.frame, 64'h00000000_E7000000); end
        tick_once();
        vectors++; if (sc_if.frame !== 64'hC3000000_00E70000) begin miscompares++; $display("FAIL frame_tick6: got %h expected %h", sc_if.frame, 64'hC3000000_00E70000); end
        vectors++; if (sc_if.gen_req !== 1'b1) begin miscompares++; $display("FAIL gen_req_second: got %b expected 1", sc_if.gen_req); end
        sc_if.col_a = 8'h00;
    endtask

    task automatic test_scoring;
        tick_once();
        vectors++; if (sc_if.frame !== 64'h00C30000_0000E700) begin miscompares++; $display("FAIL frame_head_col1: got %h expected %h", sc_if.frame, 64'h00C30000_0000E700); end
        vectors++; if (sc_if.score !== 8'h00) begin miscompares++; $display("FAIL score_before: got %h expected 00", sc_if.score); end
        tick_once();
        vectors++; if (sc_if.score !== 8'h01) begin miscompares++; $display("FAIL score_pass1: got %h expected 01", sc_if.score); end
        vectors++; if (sc_if.frame !== 64'h0000C300_000000E7) begin miscompares++; $display("FAIL frame_head_col0: got %h expected %h", sc_if.frame, 64'h0000C300_000000E7); end
        vectors++; if (sc_if.collision !== 1'b0) begin miscompares++; $display("FAIL no_collision_gap: got %b expected 0", sc_if.collision); end
    endtask

    task automatic test_collision;
        repeat (4) tick_once();
        vectors++; if (sc_if.frame !== 64'h00000000_0000C300) begin miscompares++; $display("FAIL frame_wall_col1: got %h expected %h", sc_if.frame, 64'h00000000_0000C300); end
        @(negedge clk) begin sc_if.bird_row = 3'd0; sc_if.tick = 1'b1; end
        @(negedge clk) sc_if.tick = 1'b0;
        vectors++; if (sc_if.frame !== 64'h00000000_0000C300) begin miscompares++; $display("FAIL hit_no_shift: got %h expected %h", sc_if.frame, 64'h00000000_0000C300); end
        vectors++; if (sc_if.score !== 8'h01) begin miscompares++; $display("FAIL hit_score: got %h expected 01", sc_if.score); end
        vectors++; if (sc_if.collision !== 1'b1) begin miscompares++; $display("FAIL hit_collision: got %b expected 1", sc_if.collision); end
        vectors++; if (sc_if.playing !== 1'b0) begin miscompares++; $display("FAIL hit_playing: got %b expected 0", sc_if.playing); end
        repeat (2) tick_once();
        vectors++; if (sc_if.frame !== 64'h00000000_0000C300) begin miscompares++; $display("FAIL hit_frozen: got %h expected %h", sc_if.frame, 64'h00000000_0000C300); end
        vectors++; if (sc_if.collision !== 1'b1) begin miscompares++; $display("FAIL hit_held: got %b expected 1", sc_if.collision); end
        pulse_start();
        vectors++; if (sc_if.frame !== 64'h0) begin miscompares++; $display("FAIL restart_frame: got %h expected %h", sc_if.frame, 64'h0); end
        vectors++; if (sc_if.score !== 8'h00) begin miscompares++; $display("FAIL restart_score: got %h expected 00", sc_if.score); end
        vectors++; if (sc_if.playing !== 1'b1) begin miscompares++; $display("FAIL restart_playing: got %b expected 1", sc_if.playing); end
        vectors++; if (sc_if.collision !== 1'b0) begin miscompares++; $display("FAIL restart_collision: got %b expected 0", sc_if.collision); end
    endtask

    task automatic test_double_wall;
        sc_if.bird_row = 3'd4; sc_if.mode = 1; sc_if.col_a = 8'hF1; sc_if.col_b = 8'hF1;
        tick_once();
        tick_once();
        vectors++; if (sc_if.frame !== 64'hF1F10000_00000000) begin miscompares++; $display("FAIL double_wall: got %h expected %h", sc_if.frame, 64'hF1F10000_00000000); end
        tick_once();
        vectors++; if (sc_if.frame !== 64'h00F1F100_00000000) begin miscompares++; $display("FAIL double_wall_gap: got %h expected %h", sc_if.frame, 64'h00F1F100_00000000); end
    endtask

    task automatic test_back_to_back_saturation;
        logic [7:0] exp9, exp10, exp_pre, exp_sat;
        int         k_pre;
`ifdef SCORE_BCD_EN
        exp9 = 8'h09; exp10 = 8'h10; exp_pre = 8'h98; exp_sat = 8'h99; k_pre = 497;
`else
        exp9 = 8'h09; exp10 = 8'h0A; exp_pre = 8'hFE; exp_sat = 8'hFF; k_pre = 1277;
`endif
        @(negedge clk) reset_n = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        sc_if.mode = 0; sc_if.col_a = 8'h80; sc_if.bird_row = 3'd4;
        pulse_start();
        sc_if.tick = 1'b1;
        for (int k = 1; k <= 1300; k++) begin
            @(negedge clk);
            if (k == 52) begin
                vectors++; if (sc_if.score !== exp9) begin miscompares++; $display("FAIL score_9: got %h expected %h", sc_if.score, exp9); end
            end
            if (k == 53) begin
                vectors++; if (sc_if.score !== exp10) begin miscompares++; $display("FAIL score_10: got %h expected %h", sc_if.score, exp10); end
            end
            if (k == k_pre) begin
                vectors++; if (sc_if.score !== exp_pre) begin miscompares++; $display("FAIL score_pre_sat: got %h expected %h", sc_if.score, exp_pre); end
            end
            if (k == k_pre + 1) begin
                vectors++; if (sc_if.score !== exp_sat) begin miscompares++; $display("FAIL score_sat: got %h expected %h", sc_if.score, exp_sat); end
            end
        end
        sc_if.tick = 1'b0;
        vectors++; if (sc_if.score !== exp_sat) begin miscompares++; $display("FAIL score_sat_hold: got %h expected %h", sc_if.score, exp_sat); end
        vectors++; if (sc_if.collision !== 1'b0) begin miscompares++; $display("FAIL sat_no_collision: got %b expected 0", sc_if.collision); end
    endtask

    task automatic test_reset_midrun;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (sc_if.frame !== 64'h0) begin miscompares++; $display("FAIL midrst_frame: got %h expected %h", sc_if.frame, 64'h0); end
        vectors++; if (sc_if.score !== 8'h00) begin miscompares++; $display("FAIL midrst_score: got %h expected 00", sc_if.score); end
        vectors++; if (sc_if.playing !== 1'b0) begin miscompares++; $display("FAIL midrst_playing: got %b expected 0", sc_if.playing); end
        vectors++; if (sc_if.gen_req !== 1'b0) begin miscompares++; $display("FAIL midrst_gen_req: got %b expected 0", sc_if.gen_req); end
        @(negedge clk) reset_n = 1'b1;
        tick_once();
        vectors++; if (sc_if.frame !== 64'h0) begin miscompares++; $display("FAIL midrst_idle_tick: got %h expected %h", sc_if.frame, 64'h0); end
        vectors++; if (sc_if.playing !== 1'b0) begin miscompares++; $display("FAIL midrst_idle_playing: got %b expected 0", sc_if.playing); end
    endtask

    initial begin
        test_reset();
        test_single_wall();
        test_scoring();
        test_collision();
        test_double_wall();
        test_back_to_back_saturation();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
- Consumes the 8-bit obstacle column patterns from the random column generator and scrolls them right-to-left across the 8x8 LED playfield frame buffer.
- Asks the generator for a new pattern after each obstacle is inserted.
- Detects bird/wall collision and keeps the score that the display and game-control logic read.

Parameters:
- GAP, 3, number of blank columns inserted after each obstacle (legal range 1..6)
- BIRD_COL, 1, playfield column holding the bird (1..6)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a new game
- tick  input  1  one-cycle scroll strobe from the game timer
- mode  input  1  generator mode: 1 = double-width wall, 0 = single wall
- col_a  input  8  first column pattern from the generator; bit = 1 is wall, 0 is gap
- col_b  input  8  second column pattern from the generator
- bird_row  input  3  current bird row (0 = top)
- gen_req  output  1  one-cycle pulse; advances the generator LFSR
- frame  output  64  playfield; column c is frame[8c+7:8c], c = 0 is leftmost
- score  output  8  obstacles passed
- collision  output  1  high while in HIT
- playing  output  1  high while in RUN

Behaviour:
- Reset (asynchronous, active-low):
  - frame = 0, score = 0, collision = 0, gen_req = 0, playing = 0.
  - State = IDLE, slot counter = 0, head-tag vector = 0, latched patterns = 0.
- States:
  - IDLE: start -> RUN. tick is ignored.
  - RUN: collision detected -> HIT. start is ignored.
  - HIT: frame, score and slot are frozen. start -> RUN.
- Entering RUN from IDLE or HIT, on the cycle start is sampled:
  - frame = 0, score = 0, tag = 0, slot = 0.
  - collision clears and playing sets on the next edge.
- Slot counter runs 0..GAP+1 and wraps to 0. It advances once per tick in RUN.
- On a tick in RUN, with no collision that cycle:
  - All columns shift left by one: column c <= column c+1. Column 0 is discarded.
  - Column 7 is loaded per slot:
    - slot 0: col_a. At the same edge, col_b and mode are latched.
    - slot 1: latched col_b if latched mode = 1, else 8'h00.
    - slots 2..GAP+1: 8'h00.
  - The tag vector shifts in parallel with the frame. tag[7] = 1 only for slot 0.
- gen_req is a single-cycle pulse on the clk cycle after each slot-0 tick.
  - The generator's new pattern therefore settles long before the next slot 0.
  - gen_req is never asserted outside RUN.
- Collision check:
  - Evaluated every clk cycle in RUN, not only on tick: frame[8*BIRD_COL + bird_row] == 1.
  - Uses the pre-shift frame.
  - If a collision and a tick occur in the same cycle, the collision wins: no shift, no score change. Next edge: state = HIT, collision = 1.
- Score:
  - Increments on a tick when tag[BIRD_COL] = 1, i.e. an obstacle head leaves the bird column, and there is no collision that cycle.
  - Saturates at 255.
- Reset mid-game: everything returns to the reset values immediately, regardless of state.

Optional Feature:
- Macro: SCORE_BCD_EN
- Defined:
  - score holds two packed BCD digits, [7:4] tens and [3:0] units.
  - Counts 0..99 and saturates at 8'h99.
  - Units digit wraps 9 -> 0 with a carry into the tens digit.
- Undefined: score is plain binary and saturates at 255.

Test Plan:
- Reset: assert reset_n = 0 mid-RUN -> immediately frame = 0, score = 0, playing = 0, gen_req = 0; state is IDLE after release, and a tick without start leaves frame = 0.
- Single-wall scroll: GAP = 3, mode = 0, col_a = 8'hE7, start, then 1 tick -> frame[63:56] = 8'hE7; gen_req pulses exactly one cycle later. After 5 ticks, column 7 shows the next col_a.
- Double wall: mode = 1, col_a = col_b = 8'hF1, 2 ticks -> columns 6 and 7 both equal 8'hF1.
- Scoring: bird_row = 4 (a gap row of 8'hE7) held, ticks continue -> score increments to 1 on the tick that moves the head from column 1 to column 0; collision stays 0.
- Collision priority: bird_row = 0 against wall 8'hE7 at BIRD_COL, tick asserted in the same cycle -> no shift, score unchanged, collision = 1, playing = 0. Further ticks leave frame unchanged; start clears frame and resumes RUN.
- Saturation: force 255 obstacle passes -> score holds at 8'hFF. With SCORE_BCD_EN defined, 100 passes -> score holds at 8'h99, and 10 passes give 8'h10.
